cell_pos_writer: RTL
====================

Name: cell_pos_writer

Overview:
- Write-side controller for one per-cell position memory, a single-port RAM with a 2-cycle read latency.
- Takes a valid/ready stream of updated particle positions from the motion-update stage.
- Packs particles into addresses 1..N. When the frame closes, it writes the particle count into address 0.
- Lets a whole cell be rebuilt after particle migration without the position cache managing addresses.

Parameters:
- DATA_WIDTH, 96, width of one memory word; packing is {posz, posy, posx}, 32 bits each.
- PARTICLE_NUM, 220, memory depth; word 0 is reserved for the count, so particle capacity is PARTICLE_NUM-1.
- ADDR_WIDTH, 8, memory address width; also the width of the count.

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse that opens a frame
- frame_end  in  1  one-cycle pulse that closes a frame
- in_valid  in  1  particle beat valid
- in_ready  out  1  particle beat accepted when in_valid && in_ready
- in_pos  in  DATA_WIDTH  particle position {posz, posy, posx}
- mem_address  out  ADDR_WIDTH  to memory address
- mem_data  out  DATA_WIDTH  to memory data
- mem_wren  out  1  memory write enable
- mem_rden  out  1  memory read enable
- mem_q  in  DATA_WIDTH  memory read data; used only with the optional feature
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the frame is committed
- overflow  out  1  sticky per frame; at least one beat was dropped
- particle_count  out  ADDR_WIDTH  count from the last committed frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; write pointer 1; memory contents untouched.
- A reset in the middle of a frame abandons it. Address 0 keeps its prior value.
- All memory-side outputs are registered.
- States: IDLE, FILL, COMMIT, DONE (plus VERIFY with the optional feature).
- IDLE:
  - frame_start → FILL; write pointer = 1; overflow cleared.
  - frame_end and in_valid are ignored.
- FILL:
  - in_ready = 1.
  - An accepted beat at cycle t gives mem_wren=1, mem_address=ptr, mem_data=in_pos at t+1; then ptr increments.
  - If ptr == PARTICLE_NUM when a beat is accepted: the beat is dropped (no write, ptr held) and overflow is set. The beat is still accepted, so the stream cannot deadlock.
  - frame_end at t → COMMIT. A beat accepted in the same cycle t is written first, at t+1.
  - frame_start while in FILL restarts the frame: ptr = 1, overflow cleared. Words already written are left in memory.
- COMMIT:
  - in_ready = 0.
  - Count write appears at t+2 for a frame_end at t: mem_address=0, mem_data = zero-extended (ptr-1) in the low ADDR_WIDTH bits.
  - particle_count updates in the same cycle as the count write.
- DONE:
  - done=1 at t+3; next state IDLE.
- busy deasserts in the cycle after done.
- mem_rden = 0 always; with the optional feature it is asserted only during VERIFY.
- Count range is 0..PARTICLE_NUM-1. An empty frame commits a count of 0.
- A frame_end arriving outside FILL is ignored.

Optional Feature:
- Macro: CELL_POS_WRITER_VERIFY_EN.
- Enabled:
  - After the count write, the FSM enters VERIFY and issues a read of address 0 (mem_rden=1 for one cycle).
  - It waits the 2-cycle read latency and compares mem_q[ADDR_WIDTH-1:0] with the committed count.
  - It adds an output port verify_err (1 bit), sticky until the next frame_start or reset.
  - done is delayed by 3 cycles.
- Disabled: no VERIFY state; mem_rden is tied 0; the verify_err port is absent.

Decomposition:
- Shared package:
  - state encoding typedef
  - POS_FIELD_WIDTH = 32
  - position-word pack/unpack field offsets, shared with the position cache and cell memory generators
- No sub-module: the FSM plus pointer is too small to split. The verify logic stays inline under the macro.

Test Plan:
- Basic frame:
  - Stimulus: frame_start; 3 beats back-to-back; frame_end in the cycle after the last beat.
  - Response: writes to addresses 1, 2, 3 with the matching data; then address 0 = 3; done one cycle later; particle_count = 3.
- Empty frame:
  - Stimulus: frame_start followed immediately by frame_end.
  - Response: a single write of address 0 = 0; done asserted; overflow = 0.
- Overflow:
  - Stimulus: 221 beats, then frame_end.
  - Response: 219 writes to addresses 1..219; overflow = 1; address 0 = 219; in_ready never drops during FILL.
- Same-cycle close:
  - Stimulus: in_valid and frame_end asserted in the same cycle, after 4 beats.
  - Response: a 5th write at t+1; count 5 written at t+2.
- Reset and restart:
  - Stimulus: rst_n pulsed low after 2 beats.
  - Response: all outputs 0 immediately; no address-0 write. A following full frame of 1 beat commits count 1.
- Verify (CELL_POS_WRITER_VERIFY_EN):
  - Stimulus: the bench's memory model corrupts the word-0 readback.
  - Response: verify_err = 1; done delayed 3 cycles.
  - With a correct readback, verify_err stays 0.

Source files
------------

// File: rtl/cell_pos_writer_pkg.sv
// Shared definitions for the per-cell position memory writer: FSM state
// encoding and the {posz, posy, posx} word layout used by the position
// cache and cell memory generators.
package cell_pos_writer_pkg;

  localparam int POS_FIELD_WIDTH = 32;
  localparam int POS_WORD_WIDTH  = 3 * POS_FIELD_WIDTH;

  // Field offsets inside one packed position word.
  localparam int POSX_LSB = 0;
  localparam int POSY_LSB = POSX_LSB + POS_FIELD_WIDTH;
  localparam int POSZ_LSB = POSY_LSB + POS_FIELD_WIDTH;

  typedef struct packed {
    logic [POS_FIELD_WIDTH-1:0] posz;
    logic [POS_FIELD_WIDTH-1:0] posy;
    logic [POS_FIELD_WIDTH-1:0] posx;
  } pos_word_t;

  // Writer FSM encoding; kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FILL   = 3'd1;
  localparam state_t ST_COMMIT = 3'd2;
  localparam state_t ST_DONE   = 3'd3;
  localparam state_t ST_VERIFY = 3'd4;

  function automatic logic [POS_WORD_WIDTH-1:0] pack_pos(
    input logic [POS_FIELD_WIDTH-1:0] posx,
    input logic [POS_FIELD_WIDTH-1:0] posy,
    input logic [POS_FIELD_WIDTH-1:0] posz
  );
    return {posz, posy, posx};
  endfunction

  function automatic pos_word_t unpack_pos(input logic [POS_WORD_WIDTH-1:0] word);
    pos_word_t p;
    p.posx = word[POSX_LSB +: POS_FIELD_WIDTH];
    p.posy = word[POSY_LSB +: POS_FIELD_WIDTH];
    p.posz = word[POSZ_LSB +: POS_FIELD_WIDTH];
    return p;
  endfunction

endpackage

// File: rtl/cell_pos_writer.sv
// Write-side controller for one per-cell position memory. Particles of a
// frame are packed into addresses 1..PARTICLE_NUM-1; when the frame closes
// the particle count is written into address 0.
// Optional readback check of word 0 is enabled by CELL_POS_WRITER_VERIFY_EN.
module cell_pos_writer
  import cell_pos_writer_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pos,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] particle_count
`ifdef CELL_POS_WRITER_VERIFY_EN
  ,
  output logic                  verify_err
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LP_PTR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_PTR_FULL  = ADDR_WIDTH'(PARTICLE_NUM);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_wren;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [ADDR_WIDTH-1:0] r_particle_count;

  logic                  w_room;
  logic [ADDR_WIDTH-1:0] w_count;
  logic                  w_unused_q;

  // The pointer always sits one past the last written particle.
  assign w_room  = (r_ptr != LP_PTR_FULL);
  assign w_count = r_ptr - LP_PTR_FIRST;

`ifdef CELL_POS_WRITER_VERIFY_EN
  logic       r_mem_rden;
  logic [1:0] r_vcnt;
  logic       r_verify_err;
  logic       w_verify_mismatch;

  assign w_verify_mismatch = (mem_q[ADDR_WIDTH-1:0] != r_particle_count);
  assign w_unused_q        = ^mem_q[DATA_WIDTH-1:ADDR_WIDTH];
  assign mem_rden          = r_mem_rden;
  assign verify_err        = r_verify_err;
`else
  assign w_unused_q        = ^mem_q;
  assign mem_rden          = 1'b0;
`endif

  // Frame FSM, write pointer and registered memory-side outputs.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the memory itself is outside this block and is never cleared;
      // an abandoned frame leaves address 0 holding the previous count.
      r_state          <= ST_IDLE;
      r_ptr            <= LP_PTR_FIRST;
      r_mem_address    <= '0;
      r_mem_data       <= '0;
      r_mem_wren       <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_overflow       <= 1'b0;
      r_particle_count <= '0;
`ifdef CELL_POS_WRITER_VERIFY_EN
      r_mem_rden       <= 1'b0;
      r_vcnt           <= '0;
      r_verify_err     <= 1'b0;
`endif
    end else begin
      // Strobes default low and are raised only in the cycle they apply.
      r_mem_wren <= 1'b0;
      r_done     <= 1'b0;
`ifdef CELL_POS_WRITER_VERIFY_EN
      r_mem_rden <= 1'b0;
`endif
      // busy drops the cycle after done unless a new frame opens right away.
      if (r_done) begin
        r_busy <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_state    <= ST_FILL;
            r_ptr      <= LP_PTR_FIRST;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
`ifdef CELL_POS_WRITER_VERIFY_EN
            r_verify_err <= 1'b0;
`endif
          end
        end

        ST_FILL: begin
          if (frame_start) begin
            // Restart: a beat arriving with the restart pulse is discarded.
            r_ptr      <= LP_PTR_FIRST;
            r_overflow <= 1'b0;
`ifdef CELL_POS_WRITER_VERIFY_EN
            r_verify_err <= 1'b0;
`endif
          end else begin
            if (in_valid) begin
              if (w_room) begin
                r_mem_wren    <= 1'b1;
                r_mem_address <= r_ptr;
                r_mem_data    <= in_pos;
                r_ptr         <= r_ptr + LP_PTR_FIRST;
              end else begin
                // Full cell: beat is still consumed so the stream keeps moving.
                r_overflow <= 1'b1;
              end
            end
            if (frame_end) begin
              r_state <= ST_COMMIT;
            end
          end
        end

        ST_COMMIT: begin
          r_mem_wren       <= 1'b1;
          r_mem_address    <= '0;
          r_mem_data       <= DATA_WIDTH'(w_count);
          r_particle_count <= w_count;
`ifdef CELL_POS_WRITER_VERIFY_EN
          r_vcnt  <= '0;
          r_state <= ST_VERIFY;
`else
          r_state <= ST_DONE;
`endif
        end

`ifdef CELL_POS_WRITER_VERIFY_EN
        ST_VERIFY: begin
          // One read strobe, then ride out the 2-cycle read latency.
          if (r_vcnt == 2'd0) begin
            r_mem_rden    <= 1'b1;
            r_mem_address <= '0;
          end
          r_vcnt <= r_vcnt + 2'd1;
          if (r_vcnt == 2'd2) begin
            r_state <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
`ifdef CELL_POS_WRITER_VERIFY_EN
          if (w_verify_mismatch) begin
            r_verify_err <= 1'b1;
          end
`endif
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready       = (r_state == ST_FILL);
  assign mem_address    = r_mem_address;
  assign mem_data       = r_mem_data;
  assign mem_wren       = r_mem_wren;
  assign busy           = r_busy;
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign particle_count = r_particle_count;

endmodule
